// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared constants for the seven-segment scanner.
// Segment patterns are active-low, bit order g..a in [6:0].
package sevseg_pkg;

  typedef logic [3:0] nibble_t;

  localparam int unsigned MAX_DIGITS = 8;

  // Hex glyphs 0-F, active-low g..a
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // All segments and dp dark
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Anode-idle mask: n low bits set (all anodes off, active-low)
  function automatic logic [MAX_DIGITS-1:0] AN_OFF(input int unsigned n);
    logic [MAX_DIGITS-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: nibble + decimal point -> active-low {dp, g..a}.
module seg_hex_decoder
  import sevseg_pkg::*;
(
  input  nibble_t    nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {~dp_i, SEG_PAT[nibble_i]};

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed common-anode seven-segment driver.
// Scans digits MSB first, one 2^PRESC_W-clock slot each, with a dead
// clock at slot start, PWM brightness and double-buffered display data.
// Optional build macro: SEVSEG_LZB_EN enables leading-zero blanking.
module seven_seg_scanner
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESC_W    = 16,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);
  localparam logic [MAX_DIGITS-1:0] AN_OFF_ALL = AN_OFF(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = AN_OFF_ALL[NUM_DIGITS-1:0];

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    frame_done_q, frame_done_d;
  logic                    frame_edge;

  logic [4*NUM_DIGITS-1:0] stg_digits_q, stg_digits_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d;
  logic                    pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;

  logic [NUM_DIGITS-1:0]   dark_mask;
  logic [BRIGHT_W-1:0]     phase;
  nibble_t                 cur_nib;
  logic                    cur_dp;
  logic                    lit;
  logic [7:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;

  // Prescaler and scan index; the index wrap from 0 marks the frame boundary
  always_comb begin
    presc_d    = presc_q + 1'b1;
    idx_d      = idx_q;
    frame_edge = 1'b0;
    if (&presc_q) begin
      if (idx_q == '0) begin
        idx_d      = IDX_TOP;
        frame_edge = 1'b1;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end
    frame_done_d = frame_edge;
  end

  // Double buffer: a load on the boundary clock stays pending for the next one
  always_comb begin
    stg_digits_d = stg_digits_q;
    stg_dp_d     = stg_dp_q;
    stg_blank_d  = stg_blank_q;
    pend_d       = pend_q;
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    if (frame_edge && pend_q) begin
      act_digits_d = stg_digits_q;
      act_dp_d     = stg_dp_q;
      act_blank_d  = stg_blank_q;
      pend_d       = 1'b0;
    end
    if (load) begin
      stg_digits_d = digits_in;
      stg_dp_d     = dp_in;
      stg_blank_d  = blank_in;
      pend_d       = 1'b1;
    end
  end

`ifdef SEVSEG_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_mask;
  logic                  lzb_run;

  // Zero digits above the first shown non-zero or dp digit go dark; digit 0 never
  always_comb begin
    lzb_mask = '0;
    lzb_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (!act_blank_q[i]) begin
        if (act_dp_q[i] || (act_digits_q[4*i +: 4] != 4'h0)) begin
          lzb_run = 1'b0;
        end else begin
          lzb_mask[i] = lzb_run;
        end
      end
    end
  end

  assign dark_mask = act_blank_q | lzb_mask;
`else
  assign dark_mask = act_blank_q;
`endif

  seg_hex_decoder u_dec (
    .nibble_i (cur_nib),
    .dp_i     (cur_dp),
    .seg_o    (dec_seg)
  );

  // Anode/segment next values: dead clock at prescaler 0, then PWM window
  always_comb begin
    cur_nib = act_digits_q[4*int'(idx_q) +: 4];
    cur_dp  = act_dp_q[idx_q];
    phase   = presc_q[PRESC_W-1 -: BRIGHT_W];
    lit     = (presc_q != '0) && (phase < brightness) && !dark_mask[idx_q];
    an_d    = AN_IDLE;
    seg_d   = SEG_OFF;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      seg_d       = dec_seg;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= IDX_TOP;
      frame_done_q <= 1'b0;
      stg_digits_q <= '0;
      stg_dp_q     <= '0;
      stg_blank_q  <= '1;
      pend_q       <= 1'b0;
      act_digits_q <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      an_q         <= AN_IDLE;
      seg_q        <= SEG_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      stg_digits_q <= stg_digits_d;
      stg_dp_q     <= stg_dp_d;
      stg_blank_q  <= stg_blank_d;
      pend_q       <= pend_d;
      act_digits_q <= act_digits_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed checks of scan order, PWM, staging,
// blanking/dp, leading-zero blanking (SEVSEG_LZB_EN) and async reset.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0]  cap_an  [64];
  logic [7:0]  cap_seg [64];
  logic        cap_fd  [64];
  logic [12:0] exp_v;

`ifdef SEVSEG_LZB_EN
  localparam logic [3:0] LZB_DARK = 4'b1100;
`else
  localparam logic [3:0] LZB_DARK = 4'b0000;
`endif

  seven_seg_scanner #(
    .NUM_DIGITS (4),
    .PRESC_W    (4),
    .BRIGHT_W   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .brightness (brightness),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Sample j of a frame reflects prescaler j%16 on digit 3-j/16; frame_done at j=63
  function automatic logic [12:0] exp_sample(input int j, input logic [15:0] dig,
                                             input logic [3:0] dp, input logic [3:0] dark,
                                             input logic [3:0] br);
    int p;
    int d;
    logic [3:0] an;
    logic [7:0] seg;
    p   = j % 16;
    d   = 3 - j / 16;
    an  = 4'hF;
    seg = 8'hFF;
    if ((p != 0) && (p < int'(br)) && !dark[d]) begin
      an[d]  = 1'b0;
      seg    = hex7(dig[4*d +: 4]);
      seg[7] = ~dp[d];
    end
    return {(j == 63), an, seg};
  endfunction

  // Collects one 64-clock frame; optionally pulses load after sample load_at
  task automatic capture_frame(input int load_at, input logic [15:0] ld_d,
                               input logic [3:0] ld_dp, input logic [3:0] ld_bl);
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      cap_an[j]  = an_out;
      cap_seg[j] = seg_out;
      cap_fd[j]  = frame_done;
      if (j == load_at) begin
        load      = 1'b1;
        digits_in = ld_d;
        dp_in     = ld_dp;
        blank_in  = ld_bl;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (an_out !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_an got=%b want=1111", an_out);
    end
    vectors++;
    if (seg_out !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_seg got=%h want=ff", seg_out);
    end
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_frame_done got=%b want=0", frame_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_frame();
    int k;
    load      = 1'b1;
    digits_in = 16'h1234;
    dp_in     = 4'h0;
    blank_in  = 4'h0;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      load = 1'b0;
      if (frame_done) break;
      vectors++;
      if (an_out !== 4'hF) begin
        miscompares++;
        $display("FAIL first_frame_blank k=%0d got an=%b want=1111", k, an_out);
      end
    end
    vectors++;
    if (k != 64) begin
      miscompares++;
      $display("FAIL first_frame_length got=%0d want=64", k);
    end
    capture_frame(-1, 16'h0, 4'h0, 4'h0);
    for (int j = 0; j < 64; j++) begin
      exp_v = exp_sample(j, 16'h1234, 4'h0, 4'h0, 4'hF);
      vectors++;
      if ({cap_fd[j], cap_an[j], cap_seg[j]} !== exp_v) begin
        miscompares++;
        $display("FAIL show_1234 j=%0d got fd=%b an=%b seg=%h want fd=%b an=%b seg=%h",
                 j, cap_fd[j], cap_an[j], cap_seg[j], exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_brightness();
    int lit_cnt;
    brightness = 4'h4;
    capture_frame(-1, 16'h0, 4'h0, 4'h0);
    for (int j = 0; j < 64; j++) begin
      exp_v = exp_sample(j, 16'h1234, 4'h0, 4'h0, 4'h4);
      vectors++;
      if ({cap_fd[j], cap_an[j], cap_seg[j]} !== exp_v) begin
        miscompares++;
        $display("FAIL bright4 j=%0d got fd=%b an=%b seg=%h want fd=%b an=%b seg=%h",
                 j, cap_fd[j], cap_an[j], cap_seg[j], exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
    for (int s = 0; s < 4; s++) begin
      lit_cnt = 0;
      for (int j = 16*s; j < 16*s + 16; j++) if (cap_an[j] !== 4'hF) lit_cnt++;
      vectors++;
      if (lit_cnt != 3) begin
        miscompares++;
        $display("FAIL bright4_slot_count slot=%0d got=%0d want=3", s, lit_cnt);
      end
    end
    brightness = 4'h0;
    capture_frame(-1, 16'h0, 4'h0, 4'h0);
    for (int j = 0; j < 64; j++) begin
      vectors++;
      if (cap_an[j] !== 4'hF) begin
        miscompares++;
        $display("FAIL bright0 j=%0d got an=%b want=1111", j, cap_an[j]);
      end
    end
    brightness = 4'hF;
  endtask

  task automatic test_midframe_load();
    capture_frame(20, 16'hABCD, 4'h0, 4'h0);
    for (int j = 0; j < 64; j++) begin
      exp_v = exp_sample(j, 16'h1234, 4'h0, 4'h0, 4'hF);
      vectors++;
      if ({cap_fd[j], cap_an[j], cap_seg[j]} !== exp_v) begin
        miscompares++;
        $display("FAIL midload_old j=%0d got fd=%b an=%b seg=%h want fd=%b an=%b seg=%h",
                 j, cap_fd[j], cap_an[j], cap_seg[j], exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
    capture_frame(-1, 16'h0, 4'h0, 4'h0);
    for (int j = 0; j < 64; j++) begin
      exp_v = exp_sample(j, 16'hABCD, 4'h0, 4'h0, 4'hF);
      vectors++;
      if ({cap_fd[j], cap_an[j], cap_seg[j]} !== exp_v) begin
        miscompares++;
        $display("FAIL midload_new j=%0d got fd=%b an=%b seg=%h want fd=%b an=%b seg=%h",
                 j, cap_fd[j], cap_an[j], cap_seg[j], exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_dp_blank();
    capture_frame(5, 16'h5678, 4'b0010, 4'b1000);
    for (int j = 0; j < 64; j++) begin
      exp_v = exp_sample(j, 16'hABCD, 4'h0, 4'h0, 4'hF);
      vectors++;
      if ({cap_fd[j], cap_an[j], cap_seg[j]} !== exp_v) begin
        miscompares++;
        $display("FAIL dpblank_old j=%0d got fd=%b an=%b seg=%h want fd=%b an=%b seg=%h",
                 j, cap_fd[j], cap_an[j], cap_seg[j], exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
    capture_frame(-1, 16'h0, 4'h0, 4'h0);
    for (int j = 0; j < 64; j++) begin
      exp_v = exp_sample(j, 16'h5678, 4'b0010, 4'b1000, 4'hF);
      vectors++;
      if ({cap_fd[j], cap_an[j], cap_seg[j]} !== exp_v) begin
        miscompares++;
        $display("FAIL dpblank_new j=%0d got fd=%b an=%b seg=%h want fd=%b an=%b seg=%h",
                 j, cap_fd[j], cap_an[j], cap_seg[j], exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
  endtask

  // Load on the boundary clock must wait one full extra frame
  task automatic test_boundary_load();
    capture_frame(62, 16'h9999, 4'h0, 4'h0);
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 64; j++) begin
        exp_v = exp_sample(j, 16'h5678, 4'b0010, 4'b1000, 4'hF);
        vectors++;
        if ({cap_fd[j], cap_an[j], cap_seg[j]} !== exp_v) begin
          miscompares++;
          $display("FAIL boundary_hold f=%0d j=%0d got fd=%b an=%b seg=%h want fd=%b an=%b seg=%h",
                   f, j, cap_fd[j], cap_an[j], cap_seg[j], exp_v[12], exp_v[11:8], exp_v[7:0]);
        end
      end
      capture_frame(-1, 16'h0, 4'h0, 4'h0);
    end
    for (int j = 0; j < 64; j++) begin
      exp_v = exp_sample(j, 16'h9999, 4'h0, 4'h0, 4'hF);
      vectors++;
      if ({cap_fd[j], cap_an[j], cap_seg[j]} !== exp_v) begin
        miscompares++;
        $display("FAIL boundary_new j=%0d got fd=%b an=%b seg=%h want fd=%b an=%b seg=%h",
                 j, cap_fd[j], cap_an[j], cap_seg[j], exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_lzb();
    capture_frame(10, 16'h0042, 4'h0, 4'h0);
    capture_frame(-1, 16'h0, 4'h0, 4'h0);
    for (int j = 0; j < 64; j++) begin
      exp_v = exp_sample(j, 16'h0042, 4'h0, LZB_DARK, 4'hF);
      vectors++;
      if ({cap_fd[j], cap_an[j], cap_seg[j]} !== exp_v) begin
        miscompares++;
        $display("FAIL lzb_0042 j=%0d got fd=%b an=%b seg=%h want fd=%b an=%b seg=%h",
                 j, cap_fd[j], cap_an[j], cap_seg[j], exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    repeat (41) @(negedge clk);
    vectors++;
    if ({an_out, seg_out} !== {4'b1101, 8'h99}) begin
      miscompares++;
      $display("FAIL midreset_pre got an=%b seg=%h want an=1101 seg=99", an_out, seg_out);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({an_out, seg_out, frame_done} !== {4'hF, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_async got an=%b seg=%h fd=%b want an=1111 seg=ff fd=0",
               an_out, seg_out, frame_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      vectors++;
      if (an_out !== 4'hF) begin
        miscompares++;
        $display("FAIL midreset_blank i=%0d got an=%b want=1111", i, an_out);
      end
    end
    load      = 1'b1;
    digits_in = 16'h1234;
    dp_in     = 4'h0;
    blank_in  = 4'h0;
    k = 0;
    while (k < 150) begin
      @(negedge clk);
      load = 1'b0;
      k++;
      if (an_out !== 4'hF) break;
    end
    vectors++;
    if ({an_out, seg_out} !== {4'b0111, 8'hF9}) begin
      miscompares++;
      $display("FAIL midreset_first_lit after %0d clocks got an=%b seg=%h want an=0111 seg=f9",
               k, an_out, seg_out);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_brightness();
    test_midframe_load();
    test_dp_blank();
    test_boundary_load();
    test_lzb();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
